cnt_bank_reg: RTL and testbench
===============================

// Module: cnt_bank_reg
// PURPOSE
//  Parametrised multi-channel statistics counter bank, the successor of the single counter CBB.
//  Holds CH independent counters of WIDTH bits. Each counter takes a per-channel enable and
//  increment amount, with wrap or saturate mode and a sticky overflow flag per channel.
//  Readable through a one-cycle request/ack port with optional clear-on-read.
//  Used for PCIe/DMA event and byte statistics feeding the AMBA register space.
// PARAMETERS
//  CH     8   number of counter channels (>=1)
//  WIDTH  32  counter width in bits (>=2)
//  INCW   8   increment field width per channel; INCW < WIDTH
//  SAT    0   0 = wrap modulo 2^WIDTH; 1 = saturate at all-ones
//  AW     4   read address width; 2^AW >= CH
// PORTS
//  clk_sys  in   1         system clock; all logic is on its rising edge
//  rst_n    in   1         asynchronous reset, active-low
//  cnt_en   in   CH        per-channel count enable
//  cnt_inc  in   CH*INCW   packed increment amounts; channel i = [i*INCW +: INCW]
//  cnt_clr  in   CH        per-channel synchronous clear
//  ovf      out  CH        sticky overflow flag per channel (registered)
//  rd_req   in   1         read request, single-cycle strobe; may be asserted every cycle
//  rd_addr  in   AW        channel to read, sampled with rd_req
//  rd_clr   in   1         clear-on-read qualifier, sampled with rd_req
//  rd_ack   out  1         read data valid, exactly 1 cycle after rd_req
//  rd_data  out  WIDTH     counter value, valid while rd_ack=1
//  rd_ovf   out  1         ovf flag of the read channel, valid while rd_ack=1
// BEHAVIOUR
//  Reset: while rst_n=0, all counters, ovf, rd_ack, rd_data and rd_ovf are 0 immediately (async).
//    Deassertion mid-operation resumes from zero. No request is pending after reset.
//  Per channel i, per cycle. Priority: cnt_clr > read-clear > increment.
//  - cnt_clr[i]=1: cnt<=0, ovf[i]<=0. A same-cycle increment is discarded.
//  - Read-clear (rd_req & rd_clr & rd_addr==i): cnt<=(cnt_en[i] ? inc : 0), ovf[i]<=0.
//    An increment in the clear cycle is kept, never lost.
//  - cnt_en[i]=1: compute sum=cnt+inc at WIDTH+1 bits.
//    SAT=0: cnt<=sum[WIDTH-1:0]; ovf[i]<=1 if sum[WIDTH]=1.
//    SAT=1: cnt<=sum[WIDTH] ? all-ones : sum; ovf[i]<=1 if sum[WIDTH]=1.
//    Landing exactly on all-ones does not set ovf.
//  - inc=0 with cnt_en=1 leaves cnt unchanged.
//  - ovf is sticky. It clears only on reset, cnt_clr or read-clear of that channel.
//  Read port:
//  - Non-blocking with fixed latency 1. A request in cycle T gives rd_ack=1 in cycle T+1.
//  - rd_data/rd_ovf carry the value held at T, before any update made in cycle T.
//  - rd_ack is 0 in any cycle not following a request. rd_data/rd_ovf hold their last value while rd_ack=0.
//  - Back-to-back requests give back-to-back acks, in order. There is no stall and no backpressure.
//  - rd_addr >= CH: ack still returned, rd_data=0, rd_ovf=0, no channel cleared.
//  - A read-clear on channel i coinciding with cnt_clr[i]: counter ends 0; read data is still the pre-clear value.
//  All outputs are registered. There are no combinational paths from inputs to outputs.
// TESTING
//  1. Count 37 on ch3 with inc=1, then pulse rst_n=0 for 1 ns between edges
//     -> ovf=0, rd_ack=0 at once; a read of ch3 then returns 0.
//  2. WIDTH=8, SAT=0: ch0 reaches 250, then en with inc=10
//     -> cnt=4, ovf[0]=1; a read gives rd_data=4, rd_ovf=1.
//  3. WIDTH=8, SAT=1: ch0=250, inc=10 -> cnt=255, ovf[0]=1.
//     A further inc=3 keeps 255. Reaching 255 exactly from 250 with inc=5 leaves ovf=0.
//  4. ch2=100: rd_req, rd_clr=1, addr=2, with cnt_en[2]=1 and inc=5 in the same cycle
//     -> next cycle rd_ack=1, rd_data=100; counter=5, ovf[2]=0.
//  5. cnt_clr[1] and cnt_en[1] (inc=7) together on ch1=20 -> ch1=0.
//     Same-cycle read of ch1 returns 20.
//  6. CH=8, AW=4: requests to addr 0, 1, 9 on three consecutive cycles
//     -> three consecutive acks with ch0, ch1, then 0/0. No counter changes.

Source files
------------

// File: rtl/cnt_bank_reg.sv
// Multi-channel statistics counter bank with per-channel wrap/saturate, sticky overflow
// and a fixed one-cycle-latency read port with optional clear-on-read.
module cnt_bank_reg #(
  parameter int CH    = 8,
  parameter int WIDTH = 32,
  parameter int INCW  = 8,
  parameter int SAT   = 0,
  parameter int AW    = 4
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [CH-1:0]     cnt_en,
  input  logic [CH*INCW-1:0] cnt_inc,
  input  logic [CH-1:0]     cnt_clr,
  output logic [CH-1:0]     ovf,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_clr,
  output logic              rd_ack,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_ovf
);

  logic [WIDTH-1:0] w_cnt_all [CH];
  logic [WIDTH-1:0] w_rd_data;
  logic             w_rd_ovf;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [INCW-1:0]  w_inc;
    logic [WIDTH:0]   w_sum;
    logic             w_rd_clr;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;

    assign w_inc    = cnt_inc[g*INCW +: INCW];
    assign w_sum    = {1'b0, r_cnt} + {{(WIDTH+1-INCW){1'b0}}, w_inc};
    assign w_rd_clr = rd_req & rd_clr & (rd_addr == AW'(g));

    // Priority: synchronous clear, then read-clear (keeps a same-cycle increment), then count.
    always_comb begin
      // NOTE: hold values are assigned first so every path drives both outputs; no latch.
      w_cnt_nxt = r_cnt;
      w_ovf_nxt = r_ovf;
      if (cnt_clr[g]) begin
        w_cnt_nxt = '0;
        w_ovf_nxt = 1'b0;
      end else if (w_rd_clr) begin
        w_cnt_nxt = cnt_en[g] ? {{(WIDTH-INCW){1'b0}}, w_inc} : '0;
        w_ovf_nxt = 1'b0;
      end else if (cnt_en[g]) begin
        if ((SAT != 0) && w_sum[WIDTH]) w_cnt_nxt = '1;
        else                            w_cnt_nxt = w_sum[WIDTH-1:0];
        w_ovf_nxt = r_ovf | w_sum[WIDTH];
      end
    end

    // NOTE: counters are state visible after reset, so each one is reset rather than left as RAM.
    always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end

    assign w_cnt_all[g] = r_cnt;
    assign ovf[g]       = r_ovf;
  end

  // Out-of-range addresses match no channel and read back as zero.
  always_comb begin
    w_rd_data = '0;
    w_rd_ovf  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (rd_addr == AW'(i)) begin
        w_rd_data = w_cnt_all[i];
        w_rd_ovf  = ovf[i];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_data <= w_rd_data;
        rd_ovf  <= w_rd_ovf;
      end
    end
  end

endmodule

// File: tb/tb_cnt_bank_reg.sv
// Scoreboard bench for cnt_bank_reg: a wrap instance and a saturate instance share stimulus;
// reads push expected responses, a negedge monitor pops them when acks arrive.
module tb_cnt_bank_reg;

  localparam int CH = 8, WIDTH = 8, INCW = 7, AW = 4;

  typedef struct {
    int unsigned due;
    logic [7:0]  d0;
    logic        o0;
    logic [7:0]  d1;
    logic        o1;
  } exp_t;

  logic              clk_sys = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     cnt_en;
  logic [CH*INCW-1:0] cnt_inc;
  logic [CH-1:0]     cnt_clr;
  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic              rd_clr;
  logic [CH-1:0]     ovf0, ovf1;
  logic              rd_ack0, rd_ack1;
  logic [WIDTH-1:0]  rd_data0, rd_data1;
  logic              rd_ovf0, rd_ovf1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  cnt_bank_reg #(.CH(CH), .WIDTH(WIDTH), .INCW(INCW), .SAT(0), .AW(AW)) u_dut_wrap (
    .clk_sys(clk_sys), .rst_n(rst_n), .cnt_en(cnt_en), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr),
    .ovf(ovf0), .rd_req(rd_req), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rd_ack(rd_ack0), .rd_data(rd_data0), .rd_ovf(rd_ovf0)
  );

  cnt_bank_reg #(.CH(CH), .WIDTH(WIDTH), .INCW(INCW), .SAT(1), .AW(AW)) u_dut_sat (
    .clk_sys(clk_sys), .rst_n(rst_n), .cnt_en(cnt_en), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr),
    .ovf(ovf1), .rd_req(rd_req), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rd_ack(rd_ack1), .rd_data(rd_data1), .rd_ovf(rd_ovf1)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack must line up with the oldest outstanding request.
  always @(negedge clk_sys) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      check("rd_ack_wrap", 32'(rd_ack0), 32'd1);
      check("rd_ack_sat",  32'(rd_ack1), 32'd1);
      check("rd_data_wrap", 32'(rd_data0), 32'(mon_e.d0));
      check("rd_ovf_wrap",  32'(rd_ovf0),  32'(mon_e.o0));
      check("rd_data_sat",  32'(rd_data1), 32'(mon_e.d1));
      check("rd_ovf_sat",   32'(rd_ovf1),  32'(mon_e.o1));
    end else if (rd_ack0 || rd_ack1) begin
      check("unexpected_ack", {30'd0, rd_ack1, rd_ack0}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [7:0] d0, input logic o0,
                              input logic [7:0] d1, input logic o1);
    exp_t e;
    e.due = 0; e.d0 = d0; e.o0 = o0; e.d1 = d1; e.o1 = o1;
    return e;
  endfunction

  task automatic idle_inputs();
    cnt_en = '0; cnt_inc = '0; cnt_clr = '0;
    rd_req = 1'b0; rd_addr = '0; rd_clr = 1'b0;
  endtask

  // One clock cycle of stimulus; a pushed read expects its ack one cycle later.
  task automatic step(input logic [CH-1:0] en, input logic [CH*INCW-1:0] inc,
                      input logic [CH-1:0] clr, input logic req, input logic [AW-1:0] addr,
                      input logic rclr, input logic push, input exp_t e);
    exp_t ee;
    cnt_en = en; cnt_inc = inc; cnt_clr = clr;
    rd_req = req; rd_addr = addr; rd_clr = rclr;
    if (req && push) begin
      ee = e;
      ee.due = cyc + 1;
      sb_q.push_back(ee);
    end
    @(posedge clk_sys);
    #1;
    idle_inputs();
  endtask

  function automatic logic [CH*INCW-1:0] inc_at(input int ch, input logic [INCW-1:0] amt);
    logic [CH*INCW-1:0] v;
    v = '0;
    v[ch*INCW +: INCW] = amt;
    return v;
  endfunction

  task automatic cnt(input int ch, input logic [INCW-1:0] amt);
    step(CH'(1) << ch, inc_at(ch, amt), '0, 1'b0, '0, 1'b0, 1'b0, mk(0, 0, 0, 0));
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic rclr,
                    input logic [7:0] d0, input logic o0, input logic [7:0] d1, input logic o1);
    step('0, '0, '0, 1'b1, addr, rclr, 1'b1, mk(d0, o0, d1, o1));
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("reset_ovf_wrap", 32'(ovf0), 32'd0);
    check("reset_rd_ack",   {30'd0, rd_ack1, rd_ack0}, 32'd0);
    check("reset_rd_data",  32'(rd_data0), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk_sys);
    #1;

    // Count 37 on ch3.
    for (int i = 0; i < 37; i++) cnt(3, 7'd1);
    rd(4'd3, 1'b0, 8'd37, 1'b0, 8'd37, 1'b0);

    // ch0 to 250, then +10: wrap gives 4, saturate gives 255; both flag overflow.
    cnt(0, 7'd125);
    cnt(0, 7'd125);
    cnt(0, 7'd10);
    check("ovf_wrap_ch0", 32'(ovf0), 32'h01);
    check("ovf_sat_ch0",  32'(ovf1), 32'h01);
    rd(4'd0, 1'b0, 8'd4, 1'b1, 8'd255, 1'b1);
    cnt(0, 7'd3);
    rd(4'd0, 1'b0, 8'd7, 1'b1, 8'd255, 1'b1);

    // ch4 lands exactly on all-ones: no overflow; inc=0 holds; +1 then overflows.
    cnt(4, 7'd125);
    cnt(4, 7'd125);
    cnt(4, 7'd5);
    check("ovf_exact_wrap", 32'(ovf0), 32'h01);
    check("ovf_exact_sat",  32'(ovf1), 32'h01);
    rd(4'd4, 1'b0, 8'd255, 1'b0, 8'd255, 1'b0);
    cnt(4, 7'd0);
    rd(4'd4, 1'b0, 8'd255, 1'b0, 8'd255, 1'b0);
    cnt(4, 7'd1);
    check("ovf_wrap_ch4", 32'(ovf0), 32'h11);
    check("ovf_sat_ch4",  32'(ovf1), 32'h11);
    rd(4'd4, 1'b0, 8'd0, 1'b1, 8'd255, 1'b1);

    // Short async reset pulse while an ack is being presented.
    step('0, '0, '0, 1'b1, 4'd3, 1'b0, 1'b0, mk(0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("pulse_ovf_wrap", 32'(ovf0), 32'd0);
    check("pulse_ovf_sat",  32'(ovf1), 32'd0);
    check("pulse_rd_ack",   {30'd0, rd_ack1, rd_ack0}, 32'd0);
    check("pulse_rd_data",  32'(rd_data0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_sys);
    #1;
    rd(4'd3, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    rd(4'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

    // Read-clear on ch2 with a same-cycle increment of 5.
    cnt(2, 7'd100);
    step(CH'(1) << 2, inc_at(2, 7'd5), '0, 1'b1, 4'd2, 1'b1, 1'b1, mk(100, 0, 100, 0));
    rd(4'd2, 1'b0, 8'd5, 1'b0, 8'd5, 1'b0);

    // Read-clear drops a sticky overflow on ch5.
    cnt(5, 7'd127);
    cnt(5, 7'd127);
    cnt(5, 7'd3);
    check("ovf_wrap_ch5", 32'(ovf0), 32'h20);
    check("ovf_sat_ch5",  32'(ovf1), 32'h20);
    rd(4'd5, 1'b1, 8'd1, 1'b1, 8'd255, 1'b1);
    check("rdclr_ovf_wrap", 32'(ovf0), 32'd0);
    check("rdclr_ovf_sat",  32'(ovf1), 32'd0);
    rd(4'd5, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

    // cnt_clr beats a same-cycle increment and read-clear; read still sees 20.
    cnt(1, 7'd20);
    step(CH'(1) << 1, inc_at(1, 7'd7), CH'(1) << 1, 1'b1, 4'd1, 1'b1, 1'b1, mk(20, 0, 20, 0));
    rd(4'd1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

    // Back-to-back reads including out-of-range addresses (one with clear-on-read).
    cnt(0, 7'd9);
    cnt(1, 7'd20);
    rd(4'd0, 1'b0, 8'd9, 1'b0, 8'd9, 1'b0);
    rd(4'd1, 1'b0, 8'd20, 1'b0, 8'd20, 1'b0);
    rd(4'd9, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
    rd(4'd8, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    rd(4'd0, 1'b0, 8'd9, 1'b0, 8'd9, 1'b0);
    rd(4'd1, 1'b0, 8'd20, 1'b0, 8'd20, 1'b0);

    // Read returns the pre-update value when counting in the same cycle.
    step(CH'(1), inc_at(0, 7'd1), '0, 1'b1, 4'd0, 1'b0, 1'b1, mk(9, 0, 9, 0));
    rd(4'd0, 1'b0, 8'd10, 1'b0, 8'd10, 1'b0);

    // Outputs hold while no ack is presented.
    step('0, '0, '0, 1'b0, '0, 1'b0, 1'b0, mk(0, 0, 0, 0));
    step('0, '0, '0, 1'b0, '0, 1'b0, 1'b0, mk(0, 0, 0, 0));
    check("hold_rd_ack",   {30'd0, rd_ack1, rd_ack0}, 32'd0);
    check("hold_rd_data_wrap", 32'(rd_data0), 32'd10);
    check("hold_rd_data_sat",  32'(rd_data1), 32'd10);

    for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b0, '0, 1'b0, 1'b0, mk(0, 0, 0, 0));
    check("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
